// File: rtl/puf_eval_ctrl.sv
// Ring-oscillator PUF evaluation sequencer: per response bit it clears, settles, gates and compares two counters.
// Optional macro PUF_MARGIN_EN adds per-bit unstable flags when |count_a-count_b| < MARGIN.
module puf_eval_ctrl #(
    parameter int NBITS         = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int WINDOW_CYCLES = 1024,
    parameter int MARGIN        = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  challenge,
    input  logic [15:0] count_a,
    input  logic [15:0] count_b,
    output logic        ro_en,
    output logic        cnt_clr,
    output logic        cnt_gate,
    output logic [3:0]  sel_a,
    output logic [3:0]  sel_b,
    output logic        busy,
    output logic        done,
    output logic [15:0] resp,
    output logic [15:0] unstable
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SETTLE,
        MEASURE,
        HOLD,
        COMPARE,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  k_q, k_d;
    logic [7:0]  chal_q, chal_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] resp_q, resp_d;
    logic [3:0]  sel_a_raw;
    logic [3:0]  sel_b_raw;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            chal_q  <= '0;
            cnt_q   <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            chal_q  <= chal_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        chal_d  = chal_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    chal_d  = challenge;
                    k_d     = '0;
                    resp_d  = '0;
                    cnt_d   = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == 16'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = MEASURE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            MEASURE: begin
                if (cnt_q == 16'(WINDOW_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HOLD: begin
                // Two cycles lets the counter synchronisers catch up after the gate closes.
                if (cnt_q == 16'd1) begin
                    cnt_d   = '0;
                    state_d = COMPARE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            COMPARE: begin
                resp_d[k_q] = (count_a > count_b);
                if (k_q == 4'(NBITS - 1)) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + 4'd1;
                    state_d = CLEAR;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A colliding B select is nudged to the next oscillator so the pair is never the same ring.
    assign sel_a_raw = chal_q[3:0] + k_q;
    always_comb begin
        sel_b_raw = chal_q[7:4] + k_q;
        if (sel_b_raw == sel_a_raw) begin
            sel_b_raw = sel_a_raw + 4'd1;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign cnt_clr  = (state_q == CLEAR);
    assign cnt_gate = (state_q == MEASURE);
    assign ro_en    = (state_q == SETTLE) || (state_q == MEASURE);
    assign sel_a    = busy ? sel_a_raw : 4'd0;
    assign sel_b    = busy ? sel_b_raw : 4'd0;
    assign resp     = resp_q;

`ifdef PUF_MARGIN_EN
    logic [15:0] unstable_q, unstable_d;
    logic [16:0] diff;

    assign diff = (count_a >= count_b) ? ({1'b0, count_a} - {1'b0, count_b})
                                       : ({1'b0, count_b} - {1'b0, count_a});

    always_comb begin
        unstable_d = unstable_q;
        if (state_q == IDLE && start) begin
            unstable_d = '0;
        end else if (state_q == COMPARE) begin
            unstable_d[k_q] = (diff < 17'(MARGIN));
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            unstable_q <= '0;
        end else begin
            unstable_q <= unstable_d;
        end
    end

    assign unstable = unstable_q;
`else
    assign unstable = '0;
`endif

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed bench for puf_eval_ctrl: full evaluations, select collisions, ties, ignored starts and reset abort.
module tb_puf_eval_ctrl;

    localparam int NB  = 8;
    localparam int SC  = 4;
    localparam int WC  = 1024;
    localparam int LAT = 8257;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  challenge;
    logic [15:0] count_a;
    logic [15:0] count_b;
    logic        ro_en;
    logic        cnt_clr;
    logic        cnt_gate;
    logic [3:0]  sel_a;
    logic [3:0]  sel_b;
    logic        busy;
    logic        done;
    logic [15:0] resp;
    logic [15:0] unstable;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  exp_ch = 8'h00;
    int          done_seen = 0;
    int          mon_idx = 0;
    int          gate_cnt = 0;
    int          settle_cnt = 0;
    logic        prev_gate = 1'b0;
    logic [3:0]  clr_sel_a = 4'd0;
    logic [3:0]  clr_sel_b = 4'd0;
    logic [3:0]  ea;
    logic [3:0]  eb;

    puf_eval_ctrl #(
        .NBITS(NB),
        .SETTLE_CYCLES(SC),
        .WINDOW_CYCLES(WC),
        .MARGIN(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .challenge(challenge),
        .count_a(count_a),
        .count_b(count_b),
        .ro_en(ro_en),
        .cnt_clr(cnt_clr),
        .cnt_gate(cnt_gate),
        .sel_a(sel_a),
        .sel_b(sel_b),
        .busy(busy),
        .done(done),
        .resp(resp),
        .unstable(unstable)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Per-bit monitor: select values, their stability, and settle/window lengths.
    always @(negedge clk) begin
        if (rst_n) begin
            prev_gate  = 1'b0;
            gate_cnt   = 0;
            settle_cnt = 0;
            mon_idx    = 0;
        end else begin
            if (done) done_seen++;
            if (!busy) mon_idx = 0;
            if (cnt_clr) begin
                ea = exp_ch[3:0] + 4'(mon_idx);
                eb = exp_ch[7:4] + 4'(mon_idx);
                if (eb == ea) eb = ea + 4'd1;
                check($sformatf("sel_a_bit%0d", mon_idx), 32'(sel_a), 32'(ea));
                check($sformatf("sel_b_bit%0d", mon_idx), 32'(sel_b), 32'(eb));
                clr_sel_a  = sel_a;
                clr_sel_b  = sel_b;
                settle_cnt = 0;
                gate_cnt   = 0;
                mon_idx++;
            end
            if (ro_en && !cnt_gate) settle_cnt++;
            if (cnt_gate) gate_cnt++;
            if (!cnt_gate && prev_gate) begin
                check("sel_stable", {24'd0, sel_a, sel_b}, {24'd0, clr_sel_a, clr_sel_b});
                check("settle_len", 32'(settle_cnt), 32'(SC));
                check("window_len", 32'(gate_cnt), 32'(WC));
            end
            prev_gate = cnt_gate;
        end
    end

    task automatic run_eval(input logic [7:0] ch, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] er, input logic [15:0] eu, input bit mid_start);
        int   lat;
        int   d0;
        logic got;
        count_a   = a;
        count_b   = b;
        @(negedge clk);
        exp_ch    = ch;
        challenge = ch;
        d0        = done_seen;
        start     = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start     = 1'b0;
        challenge = ~ch;
        got       = done;
        while (!got && lat < 20000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = (mid_start && (lat == 3 || lat == 5000)) ? 1'b1 : 1'b0;
            got   = done;
        end
        start = 1'b0;
        check("done_reached", 32'(got), 32'd1);
        check("latency", 32'(lat), 32'(LAT));
        check("busy_in_done", 32'(busy), 32'd1);
        check("resp", 32'(resp), 32'(er));
        check("unstable", 32'(unstable), 32'(eu));
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("done_count", 32'(done_seen - d0), 32'd1);
        repeat (5) @(negedge clk);
        check("resp_held", 32'(resp), 32'(er));
    endtask

    task automatic reset_mid_run();
        int   n;
        int   d0;
        logic prev;
        count_a   = 16'd500;
        count_b   = 16'd400;
        @(negedge clk);
        exp_ch    = 8'h21;
        challenge = 8'h21;
        d0        = done_seen;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Wait for the second bit's measurement window so resp[0] is already set.
        n = 0;
        prev = 1'b0;
        begin : wait_gate
            int rises;
            rises = 0;
            while (rises < 2 && n < 3000) begin
                @(negedge clk);
                n++;
                if (cnt_gate && !prev) rises++;
                prev = cnt_gate;
            end
            check("reached_measure", 32'(rises), 32'd2);
        end
        repeat (100) @(negedge clk);
        check("pre_reset_resp", 32'(resp), 32'h1);
        check("pre_reset_ro_en", 32'(ro_en), 32'd1);
        rst_n = 1'b1;
        #1;
        check("rst_ro_en", 32'(ro_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gate", 32'(cnt_gate), 32'd0);
        check("rst_sels", {24'd0, sel_a, sel_b}, 32'd0);
        check("rst_resp", 32'(resp), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (40) @(negedge clk);
        check("no_done_after_abort", 32'(done_seen - d0), 32'd0);
        check("idle_after_abort", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b1;
        start     = 1'b0;
        challenge = 8'h00;
        count_a   = 16'd0;
        count_b   = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {20'd0, ro_en, cnt_clr, cnt_gate, busy, done, 3'd0, sel_a, sel_b},
              32'd0);
        check("reset_resp", 32'(resp), 32'd0);
        check("reset_unstable", 32'(unstable), 32'd0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_no_start", 32'(busy), 32'd0);

        // Normal run: sel_a 1..8, sel_b 2..9, A always faster.
        run_eval(8'h21, 16'd500, 16'd400, 16'h00FF, 16'h0000, 1'b0);
        // Collision: sel_b = sel_a+1, B faster so all bits 0.
        run_eval(8'h33, 16'd100, 16'd900, 16'h0000, 16'h0000, 1'b0);
        // Tie with sel_a starting at F: sel_b wraps to 0.
`ifdef PUF_MARGIN_EN
        run_eval(8'hFF, 16'd300, 16'd300, 16'h0000, 16'h00FF, 1'b0);
`else
        run_eval(8'hFF, 16'd300, 16'd300, 16'h0000, 16'h0000, 1'b0);
`endif
        // Extra starts mid-run are ignored.
        run_eval(8'h21, 16'd500, 16'd400, 16'h00FF, 16'h0000, 1'b1);
`ifdef PUF_MARGIN_EN
        run_eval(8'h21, 16'd410, 16'd400, 16'h00FF, 16'h00FF, 1'b0);
        run_eval(8'h21, 16'd420, 16'd400, 16'h00FF, 16'h0000, 1'b0);
`endif
        reset_mid_run();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
